// File: rtl/sync_phase_pkg.sv
// Shared types for the phase sequencer: phase codes, marker decode and event layout.
// Pure definitions; no state, no flow control.
package sync_phase_pkg;

   typedef enum logic [2:0] {
      PH_VCTM  = 3'd0,
      PH_DELAY = 3'd1,
      PH_TEXE  = 3'd2,
      PH_LEAK  = 3'd3,
      PH_INIT  = 3'd4,
      PH_BIM   = 3'd5,
      PH_TRAIN = 3'd6,
      PH_NONE  = 3'd7
   } phase_e;

   localparam logic [19:0] MARKER_LOW20   = 20'h02013;
   localparam int          MARKER_IMM_MAX = 14;
   localparam int          EVT_TIME_W     = 32;

   typedef struct packed {
      logic [2:0]            phase;
      logic                  is_end;
      logic [EVT_TIME_W-1:0] ts;
   } evt_t;

   typedef struct packed {
      logic       hit;
      logic [2:0] phase;
      logic       is_end;
   } marker_t;

   // Marker encoding: the low 20 bits match, imm[3:1] is the phase, imm[0] flags END.
   function automatic marker_t decode_marker(input logic [31:0] inst);
      marker_t m;
      m.hit    = (inst[19:0] == MARKER_LOW20) && (inst[31:20] < 12'(MARKER_IMM_MAX));
      m.phase  = inst[23:21];
      m.is_end = inst[20];
      return m;
   endfunction

endpackage

// File: rtl/sync_evt_fifo.sv
// Multi-push (NPUSH per cycle, lane order), single-pop event FIFO; head registered, 1-cycle push-to-valid.
// Pop is applied before push; pushes beyond free slots are dropped and raise a sticky overflow flag.
module sync_evt_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 36,
   parameter int NPUSH = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NPUSH-1:0]         push_vld,
   input  logic [NPUSH-1:0][W-1:0]  push_dat,
   output logic                     pop_vld,
   input  logic                     pop_rdy,
   output logic [W-1:0]             pop_dat,
   output logic                     ovf
);
   localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL = DEPTH[AW:0];

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] rd_q, rd_d, wr;
   logic [AW:0]   cnt_q, cnt_d;
   logic [W-1:0]  head_q, head_d;
   logic          ovf_q, ovf_d;

   always_comb begin
      mem_d = mem_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (pop_rdy && (cnt_q != '0)) begin
         rd_d  = rd_q + AW'(1);
         cnt_d = cnt_q - (AW+1)'(1);
      end
      wr = rd_d + cnt_d[AW-1:0];
      for (int i = 0; i < NPUSH; i++) begin
         if (push_vld[i]) begin
            if (cnt_d < FULL) begin
               mem_d[wr] = push_dat[i];
               wr        = wr + AW'(1);
               cnt_d     = cnt_d + (AW+1)'(1);
            end else begin
               ovf_d = 1'b1;
            end
         end
      end
      // Head keeps its last value while empty so it never picks up unwritten storage.
      head_d = (cnt_d != '0) ? mem_d[rd_d] : head_q;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_q   <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         head_q <= '0;
      end else begin
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         head_q <= head_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   assign pop_vld = (cnt_q != '0);
   assign pop_dat = head_q;
   assign ovf     = ovf_q;

endmodule

// File: rtl/sync_phase_sequencer.sv
// Phase-marker tracker: nesting FSM, phase cycle counter, taint window, timestamped event FIFO; state 1 cycle after commit.
// Events never stall commit (overflow drops + sticky flag); SYNC_PHASE_TIMEOUT_EN adds a per-phase timeout.
module sync_phase_sequencer
   import sync_phase_pkg::*;
#(
   parameter int COMMIT_W   = 2,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 32
`ifdef SYNC_PHASE_TIMEOUT_EN
   , parameter int TIMEOUT  = 100000
`endif
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [COMMIT_W-1:0]   commit_valid,
   input  logic [COMMIT_W*32-1:0] commit_inst,
   output logic [2:0]            cur_phase,
   output logic                  in_phase,
   output logic                  taint_window,
   output logic [CNT_W-1:0]      phase_cycles,
   output logic                  evt_valid,
   input  logic                  evt_ready,
   output logic [2:0]            evt_phase,
   output logic                  evt_is_end,
   output logic [CNT_W-1:0]      evt_time,
   output logic                  err_order,
   output logic                  err_ovf,
   output logic                  err_timeout
);
   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_ACTIVE = 1'b1;
`ifdef SYNC_PHASE_TIMEOUT_EN
   localparam int TMO_N = 1;
`else
   localparam int TMO_N = 0;
`endif
   localparam int NPUSH = COMMIT_W + TMO_N;
   localparam int EVT_W = 4 + CNT_W;

   logic                        state_q, state_d;
   logic [2:0]                  cur_phase_q, phase_d;
   logic                        taint_q;
   logic                        err_order_q, err_order_d;
   logic                        start_seen;
   logic [CNT_W-1:0]            ts_q, phase_cycles_q;
   logic [NPUSH-1:0]            push_vld;
   logic [NPUSH-1:0][EVT_W-1:0] push_dat;
   logic [EVT_W-1:0]            head_dat;
   marker_t                     mk;
`ifdef SYNC_PHASE_TIMEOUT_EN
   logic                        tmo_fire;
   logic                        err_timeout_q;
`endif

   always_comb begin
      state_d     = state_q;
      phase_d     = cur_phase_q;
      err_order_d = err_order_q;
      start_seen  = 1'b0;
      push_vld    = '0;
      push_dat    = '0;
      mk          = '0;
`ifdef SYNC_PHASE_TIMEOUT_EN
      // Timeout closes the phase first, so same-cycle markers are applied from IDLE.
      tmo_fire = (state_q == ST_ACTIVE) && (phase_cycles_q == CNT_W'(TIMEOUT));
      if (tmo_fire) begin
         state_d     = ST_IDLE;
         push_vld[0] = 1'b1;
         push_dat[0] = {cur_phase_q, 1'b1, ts_q};
      end
`endif
      for (int i = 0; i < COMMIT_W; i++) begin
         mk = decode_marker(commit_inst[32*i +: 32]);
         if (commit_valid[i] && mk.hit) begin
            push_vld[i+TMO_N] = 1'b1;
            push_dat[i+TMO_N] = {mk.phase, mk.is_end, ts_q};
            if (!mk.is_end) begin
               if (state_d == ST_ACTIVE) err_order_d = 1'b1;
               state_d    = ST_ACTIVE;
               phase_d    = mk.phase;
               start_seen = 1'b1;
            end else if ((state_d == ST_ACTIVE) && (phase_d == mk.phase)) begin
               state_d = ST_IDLE;
            end else begin
               err_order_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         cur_phase_q    <= PH_NONE;
         taint_q        <= 1'b0;
         err_order_q    <= 1'b0;
         ts_q           <= '0;
         phase_cycles_q <= '0;
      end else begin
         state_q     <= state_d;
         cur_phase_q <= (state_d == ST_ACTIVE) ? phase_d : PH_NONE;
         taint_q     <= (state_d == ST_ACTIVE) && ((phase_d == PH_TEXE) || (phase_d == PH_LEAK));
         err_order_q <= err_order_d;
         ts_q        <= ts_q + CNT_W'(1);
         if (start_seen)
            phase_cycles_q <= '0;
         else if ((state_q == ST_ACTIVE) && (phase_cycles_q != '1))
            phase_cycles_q <= phase_cycles_q + CNT_W'(1);
      end
   end

`ifdef SYNC_PHASE_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (!reset)        err_timeout_q <= 1'b0;
      else if (tmo_fire) err_timeout_q <= 1'b1;
   end
   assign err_timeout = err_timeout_q;
`else
   assign err_timeout = 1'b0;
`endif

   sync_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EVT_W),
      .NPUSH (NPUSH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push_vld (push_vld),
      .push_dat (push_dat),
      .pop_vld  (evt_valid),
      .pop_rdy  (evt_ready),
      .pop_dat  (head_dat),
      .ovf      (err_ovf)
   );

   assign {evt_phase, evt_is_end, evt_time} = head_dat;
   assign cur_phase    = cur_phase_q;
   assign in_phase     = (state_q == ST_ACTIVE);
   assign taint_window = taint_q;
   assign phase_cycles = phase_cycles_q;
   assign err_order    = err_order_q;

endmodule

// File: tb/tb_sync_phase_sequencer.sv
// Directed bench for sync_phase_sequencer (COMMIT_W=2, FIFO_DEPTH=8, CNT_W=32; TIMEOUT=10 when enabled).
module tb_sync_phase_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  commit_valid;
   logic [63:0] commit_inst;
   logic [2:0]  cur_phase;
   logic        in_phase, taint_window;
   logic [31:0] phase_cycles;
   logic        evt_valid, evt_ready, evt_is_end;
   logic [2:0]  evt_phase;
   logic [31:0] evt_time;
   logic        err_order, err_ovf, err_timeout;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] ts;

   always #5 clock = ~clock;

   sync_phase_sequencer #(
      .COMMIT_W   (2),
      .FIFO_DEPTH (8),
      .CNT_W      (32)
`ifdef SYNC_PHASE_TIMEOUT_EN
      , .TIMEOUT  (10)
`endif
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .commit_valid (commit_valid),
      .commit_inst  (commit_inst),
      .cur_phase    (cur_phase),
      .in_phase     (in_phase),
      .taint_window (taint_window),
      .phase_cycles (phase_cycles),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_phase    (evt_phase),
      .evt_is_end   (evt_is_end),
      .evt_time     (evt_time),
      .err_order    (err_order),
      .err_ovf      (err_ovf),
      .err_timeout  (err_timeout)
   );

   // ts mirrors the timestamp the DUT holds during the current cycle.
   task automatic cycle();
      @(posedge clock);
      #1;
      ts = ts + 1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1);
      commit_valid = v;
      commit_inst  = {i1, i0};
   endtask

   task automatic do_reset();
      reset = 1'b0;
      evt_ready = 1'b0;
      drive(2'b00, 32'h0, 32'h0);
      cycle();
      cycle();
      reset = 1'b1;
      ts = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (cur_phase !== 3'd7) begin errors++; $display("FAIL reset_cur_phase got %0d exp 7", cur_phase); end
      checks++; if (in_phase !== 1'b0) begin errors++; $display("FAIL reset_in_phase got %0b exp 0", in_phase); end
      checks++; if (taint_window !== 1'b0) begin errors++; $display("FAIL reset_taint got %0b exp 0", taint_window); end
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_evt_valid got %0b exp 0", evt_valid); end
      checks++; if (phase_cycles !== 32'd0) begin errors++; $display("FAIL reset_phase_cycles got %0d exp 0", phase_cycles); end
      checks++; if ({evt_phase, evt_is_end, evt_time} !== 36'd0) begin errors++; $display("FAIL reset_evt_head got %0d/%0b/%0d exp 0/0/0", evt_phase, evt_is_end, evt_time); end
      checks++; if ({err_order, err_ovf, err_timeout} !== 3'b000) begin errors++; $display("FAIL reset_errs got %b exp 000", {err_order, err_ovf, err_timeout}); end
   endtask

   task automatic test_single_phase();
      logic [31:0] t0;
      do_reset();
      t0 = ts;
      drive(2'b01, 32'h00802013, 32'h0);
      cycle();
      drive(2'b00, 32'h0, 32'h0);
      checks++; if (cur_phase !== 3'd4) begin errors++; $display("FAIL single_cur_phase got %0d exp 4", cur_phase); end
      checks++; if (phase_cycles !== 32'd0) begin errors++; $display("FAIL single_cycles_start got %0d exp 0", phase_cycles); end
      for (int k = 1; k <= 4; k++) begin
         cycle();
         checks++; if (in_phase !== 1'b1 || phase_cycles !== 32'(k)) begin errors++; $display("FAIL single_active k=%0d got in_phase=%0b cycles=%0d exp 1/%0d", k, in_phase, phase_cycles, k); end
      end
      drive(2'b01, 32'h00902013, 32'h0);
      cycle();
      drive(2'b00, 32'h0, 32'h0);
      checks++; if (in_phase !== 1'b0 || cur_phase !== 3'd7) begin errors++; $display("FAIL single_end got in_phase=%0b cur_phase=%0d exp 0/7", in_phase, cur_phase); end
      checks++; if (phase_cycles !== 32'd5) begin errors++; $display("FAIL single_cycles_end got %0d exp 5", phase_cycles); end
      cycle();
      checks++; if (phase_cycles !== 32'd5) begin errors++; $display("FAIL single_cycles_hold got %0d exp 5", phase_cycles); end
      checks++; if (evt_valid !== 1'b1 || evt_phase !== 3'd4 || evt_is_end !== 1'b0 || evt_time !== t0) begin errors++; $display("FAIL single_evt0 got v=%0b %0d/%0b/%0d exp 1 4/0/%0d", evt_valid, evt_phase, evt_is_end, evt_time, t0); end
      evt_ready = 1'b1;
      cycle();
      checks++; if (evt_valid !== 1'b1 || evt_phase !== 3'd4 || evt_is_end !== 1'b1 || evt_time !== t0 + 5) begin errors++; $display("FAIL single_evt1 got v=%0b %0d/%0b/%0d exp 1 4/1/%0d", evt_valid, evt_phase, evt_is_end, evt_time, t0 + 5); end
      cycle();
      evt_ready = 1'b0;
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %0b exp 0", evt_valid); end
      checks++; if ({err_order, err_ovf, err_timeout} !== 3'b000) begin errors++; $display("FAIL single_errs got %b exp 000", {err_order, err_ovf, err_timeout}); end
   endtask

   task automatic test_same_cycle();
      logic [31:0] t;
      do_reset();
      t = ts;
      drive(2'b11, 32'h00402013, 32'h00502013);
      cycle();
      drive(2'b00, 32'h0, 32'h0);
      checks++; if (in_phase !== 1'b0 || cur_phase !== 3'd7 || taint_window !== 1'b0) begin errors++; $display("FAIL same_state got in=%0b ph=%0d taint=%0b exp 0/7/0", in_phase, cur_phase, taint_window); end
      checks++; if (err_order !== 1'b0) begin errors++; $display("FAIL same_err_order got %0b exp 0", err_order); end
      checks++; if (evt_valid !== 1'b1 || evt_phase !== 3'd2 || evt_is_end !== 1'b0 || evt_time !== t) begin errors++; $display("FAIL same_evt0 got v=%0b %0d/%0b/%0d exp 1 2/0/%0d", evt_valid, evt_phase, evt_is_end, evt_time, t); end
      evt_ready = 1'b1;
      cycle();
      checks++; if (evt_valid !== 1'b1 || evt_phase !== 3'd2 || evt_is_end !== 1'b1 || evt_time !== t) begin errors++; $display("FAIL same_evt1 got v=%0b %0d/%0b/%0d exp 1 2/1/%0d", evt_valid, evt_phase, evt_is_end, evt_time, t); end
      cycle();
      evt_ready = 1'b0;
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL same_drained got %0b exp 0", evt_valid); end
   endtask

   task automatic test_nesting();
      do_reset();
      drive(2'b11, 32'h00802013, 32'h00402013);
      cycle();
      drive(2'b00, 32'h0, 32'h0);
      checks++; if (cur_phase !== 3'd2 || taint_window !== 1'b1 || err_order !== 1'b1) begin errors++; $display("FAIL nest_start got ph=%0d taint=%0b err=%0b exp 2/1/1", cur_phase, taint_window, err_order); end
      drive(2'b01, 32'h00902013, 32'h0);
      cycle();
      drive(2'b00, 32'h0, 32'h0);
      checks++; if (cur_phase !== 3'd2 || in_phase !== 1'b1 || taint_window !== 1'b1) begin errors++; $display("FAIL nest_bad_end got ph=%0d in=%0b taint=%0b exp 2/1/1", cur_phase, in_phase, taint_window); end
   endtask

   task automatic test_end_while_idle();
      logic [31:0] t;
      do_reset();
      t = ts;
      drive(2'b10, 32'h0, 32'h00702013);
      cycle();
      drive(2'b00, 32'h0, 32'h0);
      checks++; if (err_order !== 1'b1 || in_phase !== 1'b0 || cur_phase !== 3'd7) begin errors++; $display("FAIL idle_end got err=%0b in=%0b ph=%0d exp 1/0/7", err_order, in_phase, cur_phase); end
      checks++; if (evt_valid !== 1'b1 || evt_phase !== 3'd3 || evt_is_end !== 1'b1 || evt_time !== t) begin errors++; $display("FAIL idle_end_evt got v=%0b %0d/%0b/%0d exp 1 3/1/%0d", evt_valid, evt_phase, evt_is_end, evt_time, t); end
      cycle();
      checks++; if (err_order !== 1'b1) begin errors++; $display("FAIL idle_end_sticky got %0b exp 1", err_order); end
   endtask

   task automatic test_overflow();
      logic [31:0] t0;
      do_reset();
      t0 = ts;
      for (int c = 0; c < 5; c++) begin
         drive(2'b11, {12'(2*c), 20'h02013}, {12'(2*c+1), 20'h02013});
         cycle();
         if (c == 3) begin
            checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_exact_fill got %0b exp 0", err_ovf); end
         end
      end
      drive(2'b00, 32'h0, 32'h0);
      checks++; if (err_ovf !== 1'b1 || err_order !== 1'b0) begin errors++; $display("FAIL ovf_flags got ovf=%0b order=%0b exp 1/0", err_ovf, err_order); end
      evt_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (evt_valid !== 1'b1 || evt_phase !== 3'(k/2) || evt_is_end !== 1'(k%2) || evt_time !== t0 + 32'(k/2)) begin
            errors++;
            $display("FAIL ovf_drain k=%0d got v=%0b %0d/%0b/%0d exp 1 %0d/%0d/%0d", k, evt_valid, evt_phase, evt_is_end, evt_time, k/2, k%2, t0 + 32'(k/2));
         end
         cycle();
      end
      evt_ready = 1'b0;
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %0b exp 0", evt_valid); end
   endtask

`ifdef SYNC_PHASE_TIMEOUT_EN
   task automatic test_timeout();
      logic [31:0] t0, tt;
      logic        found;
      do_reset();
      t0 = ts;
      drive(2'b01, 32'h00202013, 32'h0);
      cycle();
      drive(2'b00, 32'h0, 32'h0);
      found = 1'b0;
      for (int n = 0; n < 30; n++) begin
         if (phase_cycles == 32'd10) begin
            found = 1'b1;
            break;
         end
         cycle();
      end
      checks++; if (found !== 1'b1 || ts !== t0 + 11) begin errors++; $display("FAIL tmo_reach got found=%0b ts=%0d exp 1/%0d", found, ts, t0 + 11); end
      checks++; if (err_timeout !== 1'b0 || in_phase !== 1'b1) begin errors++; $display("FAIL tmo_before got err=%0b in=%0b exp 0/1", err_timeout, in_phase); end
      tt = ts;
      cycle();
      checks++; if (err_timeout !== 1'b1 || in_phase !== 1'b0 || cur_phase !== 3'd7) begin errors++; $display("FAIL tmo_fire got err=%0b in=%0b ph=%0d exp 1/0/7", err_timeout, in_phase, cur_phase); end
      checks++; if (evt_phase !== 3'd1 || evt_is_end !== 1'b0 || evt_time !== t0) begin errors++; $display("FAIL tmo_evt0 got %0d/%0b/%0d exp 1/0/%0d", evt_phase, evt_is_end, evt_time, t0); end
      evt_ready = 1'b1;
      cycle();
      evt_ready = 1'b0;
      checks++; if (evt_valid !== 1'b1 || evt_phase !== 3'd1 || evt_is_end !== 1'b1 || evt_time !== tt) begin errors++; $display("FAIL tmo_evt1 got v=%0b %0d/%0b/%0d exp 1 1/1/%0d", evt_valid, evt_phase, evt_is_end, evt_time, tt); end
   endtask
`endif

   task automatic test_reset_mid_phase();
      do_reset();
      drive(2'b01, 32'h00802013, 32'h0);
      cycle();
      drive(2'b11, 32'h00702013, 32'h00402013);
      cycle();
      drive(2'b00, 32'h0, 32'h0);
      checks++; if (err_order !== 1'b1 || cur_phase !== 3'd2 || taint_window !== 1'b1 || evt_valid !== 1'b1) begin errors++; $display("FAIL mid_setup got err=%0b ph=%0d taint=%0b v=%0b exp 1/2/1/1", err_order, cur_phase, taint_window, evt_valid); end
      reset = 1'b0;
      drive(2'b01, 32'h00802013, 32'h0);
      cycle();
      checks++; if (cur_phase !== 3'd7 || in_phase !== 1'b0 || taint_window !== 1'b0 || evt_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_state got ph=%0d in=%0b taint=%0b v=%0b exp 7/0/0/0", cur_phase, in_phase, taint_window, evt_valid); end
      checks++; if ({err_order, err_ovf, err_timeout} !== 3'b000 || phase_cycles !== 32'd0) begin errors++; $display("FAIL mid_reset_errs got %b cycles=%0d exp 000/0", {err_order, err_ovf, err_timeout}, phase_cycles); end
      reset = 1'b1;
      drive(2'b00, 32'h0, 32'h0);
      cycle();
      checks++; if (in_phase !== 1'b0 || evt_valid !== 1'b0) begin errors++; $display("FAIL mid_commit_ignored got in=%0b v=%0b exp 0/0", in_phase, evt_valid); end
   endtask

   initial begin
      ts = 0;
      reset = 1'b0;
      evt_ready = 1'b0;
      commit_valid = 2'b00;
      commit_inst = 64'h0;
      test_reset();
      test_single_phase();
      test_same_cycle();
      test_nesting();
      test_end_while_idle();
      test_overflow();
`ifdef SYNC_PHASE_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_phase();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
